// File: rtl/count_event_monitor_if.sv
// Signal bundle between a binary counter tap and count_event_monitor.
// The monitor is the slave; whoever drives the counter side holds the master modport.
interface count_event_monitor_if #(
    parameter int N = 8,
    parameter int W = 8
);
    logic [N-1:0] count_in;
    logic         load_in;
    logic [N-1:0] cmp_in;
    logic         clr_in;
    logic [2:0]   state_out;
    logic         wrap_up_out;
    logic         wrap_dn_out;
    logic         match_out;
    logic         err_out;
    logic [W-1:0] wrap_cnt_out;
    logic         sat_out;

    modport master (
        output count_in, load_in, cmp_in, clr_in,
        input  state_out, wrap_up_out, wrap_dn_out, match_out, err_out,
               wrap_cnt_out, sat_out
    );

    modport slave (
        input  count_in, load_in, cmp_in, clr_in,
        output state_out, wrap_up_out, wrap_dn_out, match_out, err_out,
               wrap_cnt_out, sat_out
    );
endinterface

// File: rtl/count_event_monitor.sv
// Classifies every step of an observed binary counter (hold/up/down/jump) and
// emits registered wrap, match and error pulses plus a saturating wrap tally.
module count_event_monitor #(
    parameter int          N   = 8,
    parameter int unsigned MAX = 2**N - 1,
    parameter int          W   = 8
) (
    input  logic                 clk,
    input  logic                 reset_al_in,
    count_event_monitor_if.slave bus
);

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_HOLD = 3'd1,
        ST_UP   = 3'd2,
        ST_DOWN = 3'd3,
        ST_JUMP = 3'd4
    } state_t;

    localparam logic [N-1:0] MAX_V = MAX[N-1:0];

    state_t       r_state;
    logic [N-1:0] r_prev;
    logic         r_load;
    logic         r_wrap_up;
    logic         r_wrap_dn;
    logic         r_match;
    logic         r_err;
    logic [W-1:0] r_wrap_cnt;
    logic         r_sat;

    logic [N-1:0] w_inc;
    logic [N-1:0] w_dec;
    logic [W-1:0] w_cnt_inc;
    state_t       w_state_nxt;
    logic         w_wrap_up;
    logic         w_wrap_dn;
    logic         w_match;
    logic         w_err;

    assign w_inc     = (r_prev == MAX_V) ? '0 : r_prev + 1'b1;
    assign w_dec     = (r_prev == '0) ? MAX_V : r_prev - 1'b1;
    assign w_cnt_inc = r_wrap_cnt + 1'b1;

    // A registered load means the counter was loaded on the previous edge, so
    // whatever value appears now is a legal jump and outranks every other check.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that skips an assignment would infer a latch.
        w_state_nxt = ST_JUMP;
        w_wrap_up   = 1'b0;
        w_wrap_dn   = 1'b0;
        w_err       = 1'b0;
        if (r_state == ST_INIT) begin
            w_state_nxt = ST_HOLD;
        end else if (r_load) begin
            w_state_nxt = ST_JUMP;
        end else if (bus.count_in > MAX_V) begin
            w_state_nxt = ST_JUMP;
            w_err       = 1'b1;
        end else if (bus.count_in == r_prev) begin
            w_state_nxt = ST_HOLD;
        end else if (bus.count_in == w_inc) begin
            w_state_nxt = ST_UP;
            w_wrap_up   = (r_prev == MAX_V);
        end else if (bus.count_in == w_dec) begin
            w_state_nxt = ST_DOWN;
            w_wrap_dn   = (r_prev == '0);
        end else begin
            w_state_nxt = ST_JUMP;
            w_err       = 1'b1;
        end
    end

    assign w_match = (r_state != ST_INIT) && (bus.count_in == bus.cmp_in) &&
                     ((r_prev != bus.cmp_in) || r_load);

    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            r_state    <= ST_INIT;
            r_prev     <= '0;
            r_load     <= 1'b0;
            r_wrap_up  <= 1'b0;
            r_wrap_dn  <= 1'b0;
            r_match    <= 1'b0;
            r_err      <= 1'b0;
            r_wrap_cnt <= '0;
            r_sat      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values, independent of statement order.
            r_state   <= w_state_nxt;
            r_prev    <= bus.count_in;
            r_load    <= bus.load_in;
            r_wrap_up <= w_wrap_up;
            r_wrap_dn <= w_wrap_dn;
            r_match   <= w_match;
            r_err     <= w_err;
            // Clear beats a coincident wrap; an all-ones tally holds and latches saturation.
            if (bus.clr_in) begin
                r_wrap_cnt <= '0;
                r_sat      <= 1'b0;
            end else if (w_wrap_up || w_wrap_dn) begin
                if (r_wrap_cnt == '1) begin
                    r_sat <= 1'b1;
                end else begin
                    r_wrap_cnt <= w_cnt_inc;
                    if (w_cnt_inc == '1) begin
                        r_sat <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.state_out    = r_state;
    assign bus.wrap_up_out  = r_wrap_up;
    assign bus.wrap_dn_out  = r_wrap_dn;
    assign bus.match_out    = r_match;
    assign bus.err_out      = r_err;
    assign bus.wrap_cnt_out = r_wrap_cnt;
    assign bus.sat_out      = r_sat;

endmodule

// File: tb/tb_count_event_monitor.sv
// Directed bench: three monitors (8-bit free-running, mod-6 with a 2-bit tally,
// 3-bit full range) share clock and reset and are driven from one vector table.
module tb_count_event_monitor;

    localparam int S_INIT = 0;
    localparam int S_HOLD = 1;
    localparam int S_UP   = 2;
    localparam int S_DOWN = 3;
    localparam int S_JUMP = 4;

    localparam int DA = 0;
    localparam int DB = 1;
    localparam int DC = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    count_event_monitor_if #(.N(8), .W(8)) bus_a ();
    count_event_monitor_if #(.N(3), .W(2)) bus_b ();
    count_event_monitor_if #(.N(3), .W(8)) bus_c ();

    count_event_monitor #(.N(8), .MAX(255), .W(8)) u_a (.clk(clk), .reset_al_in(rst_n), .bus(bus_a.slave));
    count_event_monitor #(.N(3), .MAX(5),   .W(2)) u_b (.clk(clk), .reset_al_in(rst_n), .bus(bus_b.slave));
    count_event_monitor #(.N(3), .MAX(7),   .W(8)) u_c (.clk(clk), .reset_al_in(rst_n), .bus(bus_c.slave));

    typedef struct {
        int         dut;
        logic [7:0] cnt;
        logic       ld;
        logic       clr;
        logic [2:0] st;
        logic       wu;
        logic       wd;
        logic       m;
        logic       e;
        logic [7:0] wc;
        logic       sat;
    } vec_t;

    vec_t vecs[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic void add(int dut, int cnt, bit ld, bit clr, int st,
                                bit wu, bit wd, bit m, bit e, int wc, bit sat);
        vec_t t;
        t.dut = dut;  t.cnt = 8'(cnt); t.ld = ld;   t.clr = clr;
        t.st  = 3'(st); t.wu = wu;    t.wd = wd;   t.m = m; t.e = e;
        t.wc  = 8'(wc); t.sat = sat;
        vecs.push_back(t);
    endfunction

    function automatic logic [15:0] pack(int st, bit wu, bit wd, bit m, bit e, int wc, bit sat);
        return {3'(st), wu, wd, m, e, 8'(wc), sat};
    endfunction

    function automatic string fmt(logic [15:0] p);
        return $sformatf("st=%0d wu=%0b wd=%0b m=%0b e=%0b wc=%0d sat=%0b",
                         p[15:13], p[12], p[11], p[10], p[9], p[8:1], p[0]);
    endfunction

    function automatic logic [15:0] outs(int dut);
        case (dut)
            DA:      return {bus_a.state_out, bus_a.wrap_up_out, bus_a.wrap_dn_out, bus_a.match_out,
                             bus_a.err_out, bus_a.wrap_cnt_out, bus_a.sat_out};
            DB:      return {bus_b.state_out, bus_b.wrap_up_out, bus_b.wrap_dn_out, bus_b.match_out,
                             bus_b.err_out, 6'd0, bus_b.wrap_cnt_out, bus_b.sat_out};
            default: return {bus_c.state_out, bus_c.wrap_up_out, bus_c.wrap_dn_out, bus_c.match_out,
                             bus_c.err_out, bus_c.wrap_cnt_out, bus_c.sat_out};
        endcase
    endfunction

    task automatic drive(int dut, logic [7:0] cnt, logic ld, logic clr);
        case (dut)
            DA:      begin bus_a.count_in = cnt;      bus_a.load_in = ld; bus_a.clr_in = clr; end
            DB:      begin bus_b.count_in = cnt[2:0]; bus_b.load_in = ld; bus_b.clr_in = clr; end
            default: begin bus_c.count_in = cnt[2:0]; bus_c.load_in = ld; bus_c.clr_in = clr; end
        endcase
    endtask

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %s, expected %s", name, fmt(act), fmt(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        string tag;

        bus_a.count_in = 8'd0; bus_a.load_in = 1'b0; bus_a.cmp_in = 8'd200; bus_a.clr_in = 1'b0;
        bus_b.count_in = 3'd0; bus_b.load_in = 1'b0; bus_b.cmp_in = 3'd7;   bus_b.clr_in = 1'b0;
        bus_c.count_in = 3'd0; bus_c.load_in = 1'b0; bus_c.cmp_in = 3'd2;   bus_c.clr_in = 1'b0;

        // A: 8-bit up count through 255->0, then a jump onto cmp, down step and a load.
        add(DA, 253, 0, 0, S_HOLD, 0, 0, 0, 0, 0, 0);
        add(DA, 254, 0, 0, S_UP,   0, 0, 0, 0, 0, 0);
        add(DA, 255, 0, 0, S_UP,   0, 0, 0, 0, 0, 0);
        add(DA,   0, 0, 0, S_UP,   1, 0, 0, 0, 1, 0);
        add(DA,   1, 0, 0, S_UP,   0, 0, 0, 0, 1, 0);
        add(DA,   1, 0, 0, S_HOLD, 0, 0, 0, 0, 1, 0);
        add(DA, 200, 0, 0, S_JUMP, 0, 0, 1, 1, 1, 0);
        add(DA, 200, 0, 0, S_HOLD, 0, 0, 0, 0, 1, 0);
        add(DA, 199, 0, 0, S_DOWN, 0, 0, 0, 0, 1, 0);
        add(DA, 199, 1, 0, S_HOLD, 0, 0, 0, 0, 1, 0);
        add(DA,  50, 0, 0, S_JUMP, 0, 0, 0, 0, 1, 0);
        add(DA,  51, 0, 0, S_UP,   0, 0, 0, 0, 1, 0);
        add(DA,  50, 0, 0, S_DOWN, 0, 0, 0, 0, 1, 0);
        // B: mod-6 counter, out-of-range error, then wraps until the 2-bit tally saturates.
        add(DB, 0, 1, 0, S_HOLD, 0, 0, 0, 0, 0, 0);
        add(DB, 4, 0, 0, S_JUMP, 0, 0, 0, 0, 0, 0);
        add(DB, 5, 0, 0, S_UP,   0, 0, 0, 0, 0, 0);
        add(DB, 0, 0, 0, S_UP,   1, 0, 0, 0, 1, 0);
        add(DB, 6, 0, 0, S_JUMP, 0, 0, 0, 1, 1, 0);
        add(DB, 6, 1, 0, S_JUMP, 0, 0, 0, 1, 1, 0);
        add(DB, 0, 0, 0, S_JUMP, 0, 0, 0, 0, 1, 0);
        add(DB, 5, 0, 0, S_DOWN, 0, 1, 0, 0, 2, 0);
        add(DB, 0, 0, 0, S_UP,   1, 0, 0, 0, 3, 1);
        add(DB, 5, 0, 0, S_DOWN, 0, 1, 0, 0, 3, 1);
        add(DB, 5, 0, 0, S_HOLD, 0, 0, 0, 0, 3, 1);
        add(DB, 0, 0, 0, S_UP,   1, 0, 0, 0, 3, 1);
        add(DB, 5, 0, 1, S_DOWN, 0, 1, 0, 0, 0, 0);
        add(DB, 5, 0, 0, S_HOLD, 0, 0, 0, 0, 0, 0);
        add(DB, 0, 0, 0, S_UP,   1, 0, 0, 0, 1, 0);
        // C: down count through 0->7, load onto same value, then match entry/hold/reload.
        add(DC, 0, 1, 0, S_HOLD, 0, 0, 0, 0, 0, 0);
        add(DC, 3, 0, 0, S_JUMP, 0, 0, 0, 0, 0, 0);
        add(DC, 2, 0, 0, S_DOWN, 0, 0, 1, 0, 0, 0);
        add(DC, 1, 0, 0, S_DOWN, 0, 0, 0, 0, 0, 0);
        add(DC, 0, 0, 0, S_DOWN, 0, 0, 0, 0, 0, 0);
        add(DC, 7, 0, 0, S_DOWN, 0, 1, 0, 0, 1, 0);
        add(DC, 6, 0, 0, S_DOWN, 0, 0, 0, 0, 1, 0);
        add(DC, 6, 1, 0, S_HOLD, 0, 0, 0, 0, 1, 0);
        add(DC, 6, 0, 0, S_JUMP, 0, 0, 0, 0, 1, 0);
        add(DC, 6, 1, 0, S_HOLD, 0, 0, 0, 0, 1, 0);
        add(DC, 0, 0, 0, S_JUMP, 0, 0, 0, 0, 1, 0);
        add(DC, 1, 0, 0, S_UP,   0, 0, 0, 0, 1, 0);
        add(DC, 2, 0, 0, S_UP,   0, 0, 1, 0, 1, 0);
        add(DC, 2, 0, 0, S_HOLD, 0, 0, 0, 0, 1, 0);
        add(DC, 2, 0, 0, S_HOLD, 0, 0, 0, 0, 1, 0);
        add(DC, 2, 1, 0, S_HOLD, 0, 0, 0, 0, 1, 0);
        add(DC, 2, 0, 0, S_JUMP, 0, 0, 1, 0, 1, 0);
        add(DC, 2, 0, 0, S_HOLD, 0, 0, 0, 0, 1, 0);

        #1 rst_n = 1'b0;
        #2;
        check("reset_a", outs(DA), pack(S_INIT, 0, 0, 0, 0, 0, 0));
        check("reset_b", outs(DB), pack(S_INIT, 0, 0, 0, 0, 0, 0));
        check("reset_c", outs(DC), pack(S_INIT, 0, 0, 0, 0, 0, 0));
        #4 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].dut, vecs[i].cnt, vecs[i].ld, vecs[i].clr);
            @(posedge clk);
            #1;
            tag = $sformatf("vec%0d_dut%0d", i, vecs[i].dut);
            check(tag, outs(vecs[i].dut),
                  pack(vecs[i].st, vecs[i].wu, vecs[i].wd, vecs[i].m, vecs[i].e,
                       vecs[i].wc, vecs[i].sat));
        end

        // Mid-cycle reset while an error pulse is in flight on A and B/C hold tallies.
        drive(DA, 8'd100, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("err_in_flight_a", outs(DA), pack(S_JUMP, 0, 0, 0, 1, 1, 0));
        #1 rst_n = 1'b0;
        #1;
        check("midreset_a", outs(DA), pack(S_INIT, 0, 0, 0, 0, 0, 0));
        check("midreset_b", outs(DB), pack(S_INIT, 0, 0, 0, 0, 0, 0));
        check("midreset_c", outs(DC), pack(S_INIT, 0, 0, 0, 0, 0, 0));
        drive(DA, 8'd255, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release_a", outs(DA), pack(S_HOLD, 0, 0, 0, 0, 0, 0));
        check("release_c", outs(DC), pack(S_HOLD, 0, 0, 0, 0, 0, 0));
        drive(DA, 8'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("wrap_after_reset_a", outs(DA), pack(S_UP, 1, 0, 0, 0, 1, 0));
        check("hold_on_cmp_c", outs(DC), pack(S_HOLD, 0, 0, 0, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
